// File: rtl/cpu_seq_if.sv
// cpu_seq_if: instruction-fetch, datapath-control and I/O handshake bundle
// for cpu_sequencer. The halted line is present only when CPU_SEQ_HALT_EN
// is defined.
interface cpu_seq_if;
  logic [7:0] pc;
  logic [7:0] imem_data;
  logic [7:0] ir;
  logic       acc_we;
  logic [1:0] alu_op;
  logic       src_sel;
  logic       in_valid;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready;
  logic       illegal;
`ifdef CPU_SEQ_HALT_EN
  logic       halted;
`endif

  // Sequencer side.
  modport master (
`ifdef CPU_SEQ_HALT_EN
    output halted,
`endif
    output pc, ir, acc_we, alu_op, src_sel, in_ready, out_valid, illegal,
    input  imem_data, in_valid, out_ready
  );

  // Memory / datapath / I/O side.
  modport slave (
`ifdef CPU_SEQ_HALT_EN
    input  halted,
`endif
    input  pc, ir, acc_we, alu_op, src_sel, in_ready, out_valid, illegal,
    output imem_data, in_valid, out_ready
  );
endinterface

// File: rtl/cpu_sequencer.sv
// cpu_sequencer: fetch/decode/execute control FSM for a tiny accumulator CPU.
// Opcodes 0x0-0x3 are ALU ops on the zero-extended operand, 0x4 reads the
// input port, 0x5 offers the accumulator on the output port, everything else
// is flagged as illegal and skipped.
// Optional feature macro: CPU_SEQ_HALT_EN -- opcode 0xF enters a HALT state
// that freezes pc/ir and raises halted until reset.
module cpu_sequencer (
  input logic       clk,
  input logic       rst_n,
  cpu_seq_if.master bus
);

  typedef enum logic [2:0] {
    S_FETCH    = 3'd0,
    S_DECODE   = 3'd1,
    S_EXEC     = 3'd2,
    S_WAIT_IN  = 3'd3,
    S_WAIT_OUT = 3'd4
`ifdef CPU_SEQ_HALT_EN
    ,S_HALT    = 3'd5
`endif
  } state_t;

  state_t     state_q, state_d;
  logic [7:0] pc_q, pc_d;
  logic [7:0] ir_q, ir_d;
  logic       illegal_q, illegal_d;

  logic       acc_we;
  logic [1:0] alu_op;
  logic       src_sel;
  logic       in_ready;
  logic       out_valid;

  // Next-state and output decode; strobes depend only on state (plus the
  // handshake input in the wait states).
  always_comb begin
    // NOTE: every signal gets a default before the case so no path can leave
    // it unassigned, which would otherwise infer a latch.
    state_d   = state_q;
    pc_d      = pc_q;
    ir_d      = ir_q;
    illegal_d = illegal_q;
    acc_we    = 1'b0;
    alu_op    = 2'b00;
    src_sel   = 1'b0;
    in_ready  = 1'b0;
    out_valid = 1'b0;

    unique case (state_q)
      S_FETCH: begin
        ir_d    = bus.imem_data;
        pc_d    = pc_q + 8'd1;
        state_d = S_DECODE;
      end
      S_DECODE: begin
        unique case (ir_q[7:4])
          4'h0, 4'h1, 4'h2, 4'h3: state_d = S_EXEC;
          4'h4:                   state_d = S_WAIT_IN;
          4'h5:                   state_d = S_WAIT_OUT;
`ifdef CPU_SEQ_HALT_EN
          4'hF:                   state_d = S_HALT;
`endif
          default: begin
            // Undefined opcode: flag it and move straight on to the next fetch.
            illegal_d = 1'b1;
            state_d   = S_FETCH;
          end
        endcase
      end
      S_EXEC: begin
        acc_we  = 1'b1;
        alu_op  = ir_q[5:4];
        state_d = S_FETCH;
      end
      S_WAIT_IN: begin
        in_ready = 1'b1;
        if (bus.in_valid) begin
          acc_we  = 1'b1;
          src_sel = 1'b1;
          state_d = S_FETCH;
        end
      end
      S_WAIT_OUT: begin
        out_valid = 1'b1;
        if (bus.out_ready) state_d = S_FETCH;
      end
`ifdef CPU_SEQ_HALT_EN
      S_HALT: state_d = S_HALT;
`endif
      default: state_d = S_FETCH;
    endcase
  end

  // State, program counter, instruction register and sticky illegal flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_FETCH;
      pc_q      <= 8'h00;
      ir_q      <= 8'h00;
      illegal_q <= 1'b0;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so all flops
      // update together from values sampled before the edge.
      state_q   <= state_d;
      pc_q      <= pc_d;
      ir_q      <= ir_d;
      illegal_q <= illegal_d;
    end
  end

  assign bus.pc        = pc_q;
  assign bus.ir        = ir_q;
  assign bus.acc_we    = acc_we;
  assign bus.alu_op    = alu_op;
  assign bus.src_sel   = src_sel;
  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid;
  assign bus.illegal   = illegal_q;
`ifdef CPU_SEQ_HALT_EN
  assign bus.halted    = (state_q == S_HALT);
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// tb_cpu_sequencer: scoreboard bench for cpu_sequencer. A program-level
// reference model walks the instruction memory with plain arithmetic and
// produces the expected per-cycle pc/flags/handshake levels plus a queue of
// expected datapath writes and output transfers; a monitor compares the DUT
// against them every cycle.
module tb_cpu_sequencer;

  localparam int MAXC = 1024;
`ifdef CPU_SEQ_HALT_EN
  localparam bit HALT_EN = 1'b1;
`else
  localparam bit HALT_EN = 1'b0;
`endif

  typedef struct {
    int         cyc;
    bit         is_out;
    logic [1:0] alu;
    logic       src;
    logic [7:0] pc;
    logic [7:0] ir;
  } ev_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  cpu_seq_if bus ();
  cpu_sequencer dut (.clk(clk), .rst_n(rst_n), .bus(bus));

  logic [7:0] mem [256];
  assign bus.imem_data = mem[bus.pc];

  bit         pin   [MAXC+2];
  bit         pout  [MAXC+2];
  logic [7:0] e_pc  [MAXC+2];
  bit         e_ill [MAXC+2];
  bit         e_inr [MAXC+2];
  bit         e_outv[MAXC+2];
`ifdef CPU_SEQ_HALT_EN
  bit         e_halt[MAXC+2];
`endif

  ev_t exp_q[$];
  int  n_checks = 0;
  int  n_fail   = 0;
  int  cyc      = 0;
  int  ncyc     = 0;
  bit  active   = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  function automatic void mark(int c, logic [7:0] p, bit ill, bit hlt, bit inr, bit outv);
    if (c <= ncyc) begin
      e_pc[c]   = p;
      e_ill[c]  = ill;
      e_inr[c]  = inr;
      e_outv[c] = outv;
`ifdef CPU_SEQ_HALT_EN
      e_halt[c] = hlt;
`else
      if (hlt) $display("model: halt requested without halt support");
`endif
    end
  endfunction

  function automatic void push(int c, bit is_out, logic [1:0] alu, logic src, logic [7:0] p, logic [7:0] ir);
    if (c <= ncyc) exp_q.push_back('{c, is_out, alu, src, p, ir});
  endfunction

  // Program-level model: each instruction costs fetch+decode, then an execute
  // cycle, a handshake wait, or nothing (illegal).
  function automatic void build_model();
    int         t, c;
    logic [7:0] p, a, ins;
    bit         ill, hlt;
    t = 1; p = 8'h00; ill = 1'b0; hlt = 1'b0;
    exp_q.delete();
    while (t <= ncyc) begin
      if (hlt) begin
        mark(t, p, ill, 1'b1, 1'b0, 1'b0);
        t++;
      end else begin
        a   = p;
        ins = mem[a];
        mark(t, a, ill, 1'b0, 1'b0, 1'b0);
        p = a + 8'd1;
        mark(t + 1, p, ill, 1'b0, 1'b0, 1'b0);
        if (ins[7:4] <= 4'h3) begin
          mark(t + 2, p, ill, 1'b0, 1'b0, 1'b0);
          push(t + 2, 1'b0, ins[5:4], 1'b0, p, ins);
          t += 3;
        end else if (ins[7:4] == 4'h4 || ins[7:4] == 4'h5) begin
          c = t + 2;
          while (c <= ncyc && !((ins[7:4] == 4'h4) ? pin[c] : pout[c])) begin
            mark(c, p, ill, 1'b0, ins[7:4] == 4'h4, ins[7:4] == 4'h5);
            c++;
          end
          mark(c, p, ill, 1'b0, ins[7:4] == 4'h4, ins[7:4] == 4'h5);
          push(c, ins[7:4] == 4'h5, 2'b00, ins[7:4] == 4'h4, p, ins);
          t = c + 1;
        end else if (ins[7:4] == 4'hF && HALT_EN) begin
          hlt = 1'b1;
          t += 2;
        end else begin
          ill = 1'b1;
          t += 2;
        end
      end
    end
  endfunction

  // Reset, then run n cycles with the prepared memory and handshake patterns.
  task automatic run_phase(input int n);
    ncyc = n;
    build_model();
    rst_n        = 1'b0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n  = 1'b1;
    active = 1'b1;
    for (int k = 1; k <= n; k++) begin
      cyc           = k;
      bus.in_valid  = pin[k];
      bus.out_ready = pout[k];
      @(negedge clk);
    end
    active = 1'b0;
    check("events_drained", exp_q.size(), 0);
  endtask

  task automatic fill(input logic [7:0] v);
    for (int i = 0; i < 256; i++) mem[i] = v;
  endtask

  task automatic pats(input bit vi, input bit vo);
    for (int k = 0; k < MAXC + 2; k++) begin
      pin[k]  = vi;
      pout[k] = vo;
    end
  endtask

  // Monitor: per-cycle levels against the model, transfers against the queue.
  always @(negedge clk) begin
    ev_t ev;
    #1;
    if (active) begin
      check("pc", 32'(bus.pc), 32'(e_pc[cyc]));
      check("illegal", 32'(bus.illegal), 32'(e_ill[cyc]));
      check("in_ready", 32'(bus.in_ready), 32'(e_inr[cyc]));
      check("out_valid", 32'(bus.out_valid), 32'(e_outv[cyc]));
`ifdef CPU_SEQ_HALT_EN
      check("halted", 32'(bus.halted), 32'(e_halt[cyc]));
`endif
      if (!bus.acc_we) check("idle_alu_src", 32'({bus.alu_op, bus.src_sel}), 0);
      if (bus.acc_we || (bus.out_valid && bus.out_ready)) begin
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", 32'(bus.acc_we), 32'(bus.out_valid));
          if (bus.acc_we == bus.out_valid) check("unexpected_transfer_q", exp_q.size(), 1);
        end else begin
          ev = exp_q.pop_front();
          check("ev_cycle", cyc, ev.cyc);
          check("ev_kind_out", 32'(!bus.acc_we), 32'(ev.is_out));
          check("ev_alu_op", 32'(bus.alu_op), 32'(ev.alu));
          check("ev_src_sel", 32'(bus.src_sel), 32'(ev.src));
          check("ev_pc", 32'(bus.pc), 32'(ev.pc));
          check("ev_ir", 32'(bus.ir), 32'(ev.ir));
        end
      end
    end
  end

  initial begin
    rst_n         = 1'b1;
    bus.in_valid  = 1'b1;
    bus.out_ready = 1'b1;
    fill(8'h03);
    #1 rst_n = 1'b0;
    #11;
    check("rst_pc", 32'(bus.pc), 0);
    check("rst_ir", 32'(bus.ir), 0);
    check("rst_acc_we", 32'(bus.acc_we), 0);
    check("rst_in_ready", 32'(bus.in_ready), 0);
    check("rst_out_valid", 32'(bus.out_valid), 0);
    check("rst_illegal", 32'(bus.illegal), 0);
    check("rst_alu_src", 32'({bus.alu_op, bus.src_sel}), 0);
`ifdef CPU_SEQ_HALT_EN
    check("rst_halted", 32'(bus.halted), 0);
`endif

    // Two ALU ops: writes on cycles 3 and 6.
    fill(8'h00); mem[0] = 8'h03; mem[1] = 8'h12;
    pats(1'b1, 1'b1);
    run_phase(8);

    // IN with in_valid low for cycles 3..7: in_ready high for 6 cycles.
    fill(8'h00); mem[0] = 8'h40;
    pats(1'b1, 1'b1);
    for (int k = 0; k <= 7; k++) pin[k] = 1'b0;
    run_phase(12);

    // OUT ready at once, then OUT stalled for 4 cycles.
    fill(8'h00); mem[0] = 8'h50; mem[1] = 8'h50;
    pats(1'b1, 1'b1);
    for (int k = 6; k <= 9; k++) pout[k] = 1'b0;
    run_phase(14);

    // Illegal opcode is sticky across later instructions and cleared by reset.
    fill(8'h00); mem[0] = 8'h70; mem[1] = 8'h11;
    pats(1'b1, 1'b1);
    run_phase(12);
    #2 rst_n = 1'b0;
    #1 check("illegal_cleared", 32'(bus.illegal), 0);

    // Randomized programs and handshake timing.
    for (int r = 0; r < 2; r++) begin
      for (int i = 0; i < 256; i++) mem[i] = 8'($urandom_range(0, 255));
      for (int k = 0; k < MAXC + 2; k++) begin
        pin[k]  = ($urandom_range(0, 2) == 0);
        pout[k] = ($urandom_range(0, 2) == 0);
      end
      run_phase(600);
    end

    // pc wraps 0xFF -> 0x00.
    fill(8'h10);
    pats(1'b1, 1'b1);
    run_phase(780);

    // Reset mid-WAIT_OUT drops out_valid immediately.
    fill(8'h00); mem[0] = 8'h50;
    pats(1'b0, 1'b0);
    run_phase(6);
    #2 rst_n = 1'b0;
    #1;
    check("midout_out_valid", 32'(bus.out_valid), 0);
    check("midout_pc", 32'(bus.pc), 0);
    check("midout_ir", 32'(bus.ir), 0);

    // Reset mid-WAIT_IN with data arriving: no write strobe.
    mem[0] = 8'h40;
    run_phase(5);
    #2;
    bus.in_valid = 1'b1;
    rst_n        = 1'b0;
    #1;
    check("midin_acc_we", 32'(bus.acc_we), 0);
    check("midin_in_ready", 32'(bus.in_ready), 0);

    // Restart fetches from 0x00.
    fill(8'h00); mem[0] = 8'h03;
    pats(1'b1, 1'b1);
    run_phase(6);

`ifdef CPU_SEQ_HALT_EN
    // 0xF0 at 0x02: halted from cycle 9 on, pc frozen at 0x03.
    fill(8'h00); mem[2] = 8'hF0;
    pats(1'b1, 1'b1);
    run_phase(30);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
